// File: rtl/issue_queue.sv
// issue_queue: in-order issue FIFO with busy-bit scoreboard and registered per-FU valid/ready output stage.
// Optional WB_BYPASS_EN adds wb_data and forwards a same-cycle writeback into the issuing operand.
module issue_queue #(
  parameter int DEPTH = 4,
  parameter int NUM_UNITS = 3,
  parameter int PAYLOAD_W = 64,
  parameter int REG_ADDR_W = 5,
  parameter int DATA_W = 32,
  localparam int UW = NUM_UNITS > 1 ? $clog2(NUM_UNITS) : 1,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = $clog2(DEPTH),
  localparam int NR = 1 << REG_ADDR_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enq_valid,
  output logic                  enq_ready,
  input  logic [REG_ADDR_W-1:0] enq_addra,
  input  logic [REG_ADDR_W-1:0] enq_addrb,
  input  logic                  enq_checka,
  input  logic                  enq_checkb,
  input  logic [REG_ADDR_W-1:0] enq_regdest,
  input  logic                  enq_writereg,
  input  logic [UW-1:0]         enq_unit,
  input  logic [PAYLOAD_W-1:0]  enq_payload,
  output logic [REG_ADDR_W-1:0] iss_reg_addra,
  output logic [REG_ADDR_W-1:0] iss_reg_addrb,
  input  logic [DATA_W-1:0]     reg_iss_dataa,
  input  logic [DATA_W-1:0]     reg_iss_datab,
  output logic [NUM_UNITS-1:0]  iss_valid,
  input  logic [NUM_UNITS-1:0]  iss_ready,
  output logic [DATA_W-1:0]     iss_rega,
  output logic [DATA_W-1:0]     iss_regb,
  output logic [REG_ADDR_W-1:0] iss_regdest,
  output logic                  iss_writereg,
  output logic [PAYLOAD_W-1:0]  iss_payload,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_addr,
`ifdef WB_BYPASS_EN
  input  logic [DATA_W-1:0]     wb_data,
`endif
  input  logic                  flush,
  output logic [CW-1:0]         count,
  output logic                  hazard_stall,
  output logic                  bad_unit
);
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addra;
    logic [REG_ADDR_W-1:0] addrb;
    logic [REG_ADDR_W-1:0] regdest;
    logic                  checka;
    logic                  checkb;
    logic                  writereg;
    logic [UW-1:0]         unit;
    logic [PAYLOAD_W-1:0]  payload;
  } op_t;

  op_t                  mem_q [DEPTH];
  op_t                  head;
  logic [PW-1:0]        rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]        count_q, count_d;
  logic [NR-1:0]        busy_q, busy_d;
  logic [NUM_UNITS-1:0] iss_valid_q, iss_valid_d;
  logic [DATA_W-1:0]    iss_rega_q, iss_rega_d, iss_regb_q, iss_regb_d, opa, opb;
  logic [REG_ADDR_W-1:0] iss_regdest_q, iss_regdest_d;
  logic                 iss_writereg_q, iss_writereg_d, bad_unit_q, bad_unit_d;
  logic [PAYLOAD_W-1:0] iss_payload_q, iss_payload_d;
  logic                 head_valid, bad, fwd_a, fwd_b, busy_a, busy_b, hazard;
  logic                 out_free, issue, deq, enq, clr;

  assign head = mem_q[rd_q];
  assign head_valid = count_q != '0;
  assign bad = {1'b0, head.unit} >= (UW + 1)'(NUM_UNITS);

`ifdef WB_BYPASS_EN
  assign fwd_a = wb_valid && wb_addr == head.addra && head.addra != '0;
  assign fwd_b = wb_valid && wb_addr == head.addrb && head.addrb != '0;
  assign opa = fwd_a ? wb_data : reg_iss_dataa;
  assign opb = fwd_b ? wb_data : reg_iss_datab;
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
  assign opa = reg_iss_dataa;
  assign opb = reg_iss_datab;
`endif

  // A source caught by a same-cycle writeback is clear only when forwarding exists.
  assign busy_a = head.checka && busy_q[head.addra] && !fwd_a;
  assign busy_b = head.checkb && busy_q[head.addrb] && !fwd_b;
  assign hazard = busy_a || busy_b || (head.writereg && busy_q[head.regdest]);

  assign out_free = iss_valid_q == '0 || (iss_valid_q & iss_ready) != '0;
  assign issue = head_valid && !bad && !hazard && out_free && !flush;
  assign deq = issue || (head_valid && bad && !flush);
  assign enq_ready = count_q != CW'(DEPTH);
  assign enq = enq_valid && enq_ready && !flush;
  assign clr = flush || (out_free && !issue);

  assign iss_reg_addra = head.addra;
  assign iss_reg_addrb = head.addrb;
  assign hazard_stall = head_valid && !bad && hazard;
  assign count = count_q;
  assign bad_unit = bad_unit_q;
  assign iss_valid = iss_valid_q;
  assign iss_rega = iss_rega_q;
  assign iss_regb = iss_regb_q;
  assign iss_regdest = iss_regdest_q;
  assign iss_writereg = iss_writereg_q;
  assign iss_payload = iss_payload_q;

  always_comb begin
    busy_d = busy_q;
    if (wb_valid) busy_d[wb_addr] = 1'b0;
    if (issue && head.writereg) busy_d[head.regdest] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    rd_d = flush ? '0 : deq ? (rd_q == PW'(DEPTH - 1) ? '0 : rd_q + 1'b1) : rd_q;
    wr_d = flush ? '0 : enq ? (wr_q == PW'(DEPTH - 1) ? '0 : wr_q + 1'b1) : wr_q;
    count_d = flush ? '0 : count_q + CW'(enq) - CW'(deq);
    bad_unit_d = bad_unit_q || (head_valid && bad);
    iss_valid_d = flush ? '0 : issue ? NUM_UNITS'(1) << head.unit : out_free ? '0 : iss_valid_q;
    iss_rega_d = issue ? opa : clr ? '0 : iss_rega_q;
    iss_regb_d = issue ? opb : clr ? '0 : iss_regb_q;
    iss_regdest_d = issue ? head.regdest : clr ? '0 : iss_regdest_q;
    iss_writereg_d = issue ? head.writereg : clr ? 1'b0 : iss_writereg_q;
    iss_payload_d = issue ? head.payload : clr ? '0 : iss_payload_q;
  end

  always_ff @(posedge clock)
    if (enq) mem_q[wr_q] <= '{enq_addra, enq_addrb, enq_regdest, enq_checka, enq_checkb,
                               enq_writereg, enq_unit, enq_payload};

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
      busy_q <= '0;
      bad_unit_q <= 1'b0;
      iss_valid_q <= '0;
      iss_rega_q <= '0;
      iss_regb_q <= '0;
      iss_regdest_q <= '0;
      iss_writereg_q <= 1'b0;
      iss_payload_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      count_q <= count_d;
      busy_q <= busy_d;
      bad_unit_q <= bad_unit_d;
      iss_valid_q <= iss_valid_d;
      iss_rega_q <= iss_rega_d;
      iss_regb_q <= iss_regb_d;
      iss_regdest_q <= iss_regdest_d;
      iss_writereg_q <= iss_writereg_d;
      iss_payload_q <= iss_payload_d;
    end
endmodule
